// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_EXT = 1'b1;

  localparam int CNT_W = 4;
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-way picker: fixed CPU priority or round-robin against the last owner on ties.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       cpu_prio,
  output logic       winner,
  output logic       any
);

  always_comb begin
    // NOTE: every output gets a value on every path so no latch is inferred.
    any    = |req;
    winner = REQ_CPU;
    if (&req)
      winner = cpu_prio ? REQ_CPU : ~last_grant;
    else if (req[REQ_EXT])
      winner = REQ_EXT;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises CPU and external accesses onto one single-port memory with a fixed
// access latency, returning read data and a one-cycle ready pulse per requester.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int LAT      = 2,
  parameter bit CPU_PRIO = 1'b0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ready,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic [DW-1:0] ext_rdata,
  output logic          ext_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          grant
);

  state_t state;
  cnt_t   cnt;
  logic   last_grant;
  logic   we_q;
  logic   winner;
  logic   any;

  arb_rr2 u_pick (
    .req        ({ext_req, cpu_req}),
    .last_grant (last_grant),
    .cpu_prio   (CPU_PRIO),
    .winner     (winner),
    .any        (any)
  );

  // Strobes decode from registered state only, so no req reaches an output combinationally.
  assign mem_en    = (state == ACCESS);
  assign mem_we    = mem_en & we_q;
  assign busy      = (state != IDLE);
  assign cpu_ready = (state == DONE) && (grant == REQ_CPU);
  assign ext_ready = (state == DONE) && (grant == REQ_EXT);

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= REQ_EXT;
      grant      <= REQ_CPU;
      we_q       <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rdata  <= '0;
      ext_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Only the winner's inputs are sampled; the loser waits untouched.
          if (any) begin
            grant      <= winner;
            last_grant <= winner;
            we_q       <= (winner == REQ_EXT) ? ext_we    : cpu_we;
            mem_addr   <= (winner == REQ_EXT) ? ext_addr  : cpu_addr;
            mem_wdata  <= (winner == REQ_EXT) ? ext_wdata : cpu_wdata;
            cnt        <= cnt_t'(LAT - 1);
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            if (!we_q) begin
              if (grant == REQ_EXT) ext_rdata <= mem_rdata;
              else                  cpu_rdata <= mem_rdata;
            end
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port unified instruction/data memory between two requesters.
- Requester 0 is the multicycle CPU, which issues fetch and load/store accesses from the main FSM.
- Requester 1 is an external port used for the program loader, debug or DMA.
- Serialises accesses, holds the granted request stable for a fixed memory latency, returns read data, and pulses a per-requester ready signal. The CPU stalls its FSM on ready.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- LAT, 2, memory access cycles per transfer; legal range 1..15.
- CPU_PRIO, 0: 0 means round-robin on ties; 1 means the CPU always wins ties.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  reset; asynchronous and active-low.
- cpu_req  in  1  CPU access request; held high until cpu_ready.
- cpu_we  in  1  CPU write enable (1 = store).
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_rdata  out  DW  CPU read data; registered.
- cpu_ready  out  1  one-cycle completion pulse for the CPU.
- ext_req  in  1  external access request; held high until ext_ready.
- ext_we  in  1  external write enable.
- ext_addr  in  AW  external address.
- ext_wdata  in  DW  external write data.
- ext_rdata  out  DW  external read data; registered.
- ext_ready  out  1  one-cycle completion pulse for the external port.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write strobe.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid in the last ACCESS cycle.
- busy  out  1  high in ACCESS and DONE.
- grant  out  1  owner of the current or last access (0 = CPU, 1 = external).

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = IDLE, cnt = 0, last_grant = 1, grant = 0.
  - All *_ready, mem_en, mem_we and busy are 0.
  - mem_addr, mem_wdata, cpu_rdata and ext_rdata are 0.
- All outputs are registered or decoded from state plus registers. No combinational path from any *_req to any output.
- IDLE:
  - No request: stay in IDLE.
  - Any request: pick a winner, latch its we/addr/wdata into the mem_* registers, set grant, set last_grant = winner, load cnt = LAT-1, go to ACCESS.
- Arbitration when both request:
  - CPU_PRIO = 1: CPU wins.
  - CPU_PRIO = 0: the requester != last_grant wins. last_grant resets to 1, so the CPU wins the first tie.
  - A single requester always wins.
- ACCESS:
  - mem_en = 1; mem_we = latched we for every ACCESS cycle.
  - mem_addr and mem_wdata are held constant.
  - cnt > 0: decrement cnt and stay.
  - cnt == 0: on a read, capture mem_rdata into the granted requester's rdata register; go to DONE.
- DONE:
  - The granted requester's ready = 1 for exactly this cycle; mem_en = mem_we = 0.
  - Next state is IDLE unconditionally.
- Requester rule: req is dropped in the cycle after ready, so a held req is never re-granted twice.
- Latency: request sampled in IDLE at cycle 0 → ACCESS in cycles 1..LAT → ready in cycle LAT+1. Back-to-back transfers cost LAT+2 cycles each.
- rdata:
  - Updated only on read completion for its own requester.
  - Unchanged on writes and on the other requester's completions.
- Request deasserted mid-access (protocol violation): the access still completes and ready still pulses.
- Requester arriving while busy: waits. It is sampled at the next IDLE and never lost.
- The losing requester's inputs are never sampled until it is granted.
- Reset asserted mid-access: immediate return to IDLE with all strobes 0. No ready pulse and no rdata update for the aborted access.
- LAT = 1: ACCESS lasts one cycle, with cnt already 0.

Decomposition:
- Shared package mem_arb_pkg:
  - State encoding IDLE = 0, ACCESS = 1, DONE = 2 (2-bit).
  - Requester IDs REQ_CPU = 0, REQ_EXT = 1.
  - Counter width 4.
- One sub-module, arb_rr2: a combinational 2-way picker.
  - Inputs: req[1:0], last_grant, CPU_PRIO.
  - Outputs: winner, any.

Test Plan:
- CPU read alone, LAT = 2, addr 0x10, mem returns 0xDEADBEEF:
  - mem_en high in cycles 1–2, cpu_ready pulses in cycle 3, cpu_rdata = 0xDEADBEEF.
  - ext_ready stays 0.
- External write addr 0x20, data 0x1234, LAT = 2:
  - mem_we = mem_en = 1 with addr 0x20 and data 0x1234 for 2 cycles, ext_ready in cycle 3.
  - cpu_rdata unchanged.
- Both request every cycle, CPU_PRIO = 0:
  - Grants alternate CPU, EXT, CPU, EXT, one ready every 4 cycles.
  - With CPU_PRIO = 1, the CPU wins every tie.
- EXT request arrives in the CPU's ACCESS cycle 1:
  - Not granted until the IDLE after the CPU's DONE. Its ext_addr is not visible on mem_addr before then.
- reset_n pulsed low in ACCESS:
  - Outputs go to reset values asynchronously; no ready afterwards.
  - A fresh request after release completes normally.
- LAT = 1 CPU read:
  - One ACCESS cycle, ready in cycle 2, data captured correctly.
